stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run/pause/clear/lap controller for the two-digit BCD counter chain. Takes raw push-buttons and the 1 Hz tick from the ticker, and gates that tick into the units digit. Issues a synchronous clear to both digits and provides a lap-hold display value for the LEDs. Sits between the ticker/reset generator and the `bcd_digit` chain in the top level.

## Interface
- `DEBOUNCE`, default 120000: consecutive stable cycles required to accept a button level change (10 ms at 12 MHz); benches use 4.
- `STOP_AT_MAX`, default 0: 1 = stop at 99 and enter DONE; 0 = wrap 99→00 and keep running.
- `sys_clk`  in  1  system clock, 12 MHz.
- `sys_reset`  in  1  one clock; reset is asynchronous and active-high.
- `btn_run`  in  1  raw run/pause button, active-high, asynchronous to `sys_clk`.
- `btn_clr`  in  1  raw clear button, active-high, asynchronous.
- `btn_lap`  in  1  raw lap button, active-high, asynchronous.
- `tick_in`  in  1  one-cycle tick from the ticker.
- `count`  in  8  live BCD count from the digit chain, {tens, units}.
- `tick_out`  out  1  gated tick to the units digit.
- `clr`  out  1  one-cycle synchronous clear pulse to both digits.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `display`  out  8  BCD value for the LEDs: `count`, or the lap-latched value while hold is set.

## Operation
- Each button path has a 2-flop synchronizer, a debouncer and a rising-edge detector.
  - Debouncer: a counter increments while the synced level differs from the debounced level and resets to 0 when they match.
  - When the counter reaches DEBOUNCE-1 with the levels still differing, the debounced level flips.
  - Each rising edge of the debounced level produces a one-cycle press event. Releases produce no event.
- FSM states: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
  - IDLE: run → RUN; clr → pulse `clr`, stay IDLE; lap ignored.
  - RUN: run → PAUSE; clr → pulse `clr`, go to IDLE.
  - RUN, terminal count: `tick_in` with `count`==8'h99 and STOP_AT_MAX=1 → DONE, and that tick is not forwarded.
  - PAUSE: run → RUN; clr → pulse `clr`, go to IDLE.
  - DONE: clr → pulse `clr`, go to IDLE; run and lap are ignored.
- Priority within one cycle: clr > run > lap.
  - clr together with run: only the clear happens, and the next state is IDLE.
- Tick gating: `tick_out` = `tick_in` AND state==RUN AND no clr event this cycle AND NOT terminal-stop condition.
  - With STOP_AT_MAX=0 the tick at 99 is forwarded, and the digits wrap to 00.
- Lap hold:
  - Lap event in RUN or PAUSE toggles `hold`.
  - When `hold` sets, `count` is latched into `lap_reg` on the same edge.
  - Any clr event clears `hold`.
  - `display` = `hold` ? `lap_reg` : `count`.
- Counting continues in RUN while hold is set. Only `display` is frozen.
- `count` inputs are trusted to be valid BCD. No range check is done.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `running`=0, `done`=0, `clr`=0, `hold`=0, `lap_reg`=8'h00, debounced levels 0, debounce counters 0.
  - `tick_out`=0 throughout reset.
  - `display` follows `count`.
- Reset asserted mid-operation: all of the above apply on assertion. Pending debounce progress is discarded.
- Button latency: raw input held high from edge N gives a press event on edge N+DEBOUNCE+2.
  - The state, `running`, `done` and `clr` update on edge N+DEBOUNCE+3.
- Glitches shorter than DEBOUNCE cycles (after synchronization) produce no event.
- `clr` is registered and high for exactly one cycle per accepted clear, coincident with the state becoming IDLE.
- `tick_out` is combinational from `tick_in`: same cycle, zero latency.
- `running` and `done` are registered and reflect the current state.
- `display` is combinational from `hold`, `lap_reg` and `count`.

## Test plan
(All with DEBOUNCE=4.)
1. Reset, then a run press held 10 cycles → `running`=1 exactly DEBOUNCE+3 edges after the first high sample. Each `tick_in` is forwarded to `tick_out`, and `count` advances 00→01→02.
2. A 3-cycle glitch on `btn_run` → no state change, `running` stays 0. A second press after a pause → `running` toggles 1→0, and `tick_in` pulses give `tick_out`=0.
3. STOP_AT_MAX=1 with `count`=8'h99 in RUN, then `tick_in` → `tick_out`=0, `done`=1, `running`=0. A run press is ignored. A clr press → one `clr` pulse, state IDLE.
4. STOP_AT_MAX=0 with `count`=8'h99 in RUN, then `tick_in` → `tick_out`=1, `done` stays 0, and `count` wraps to 8'h00.
5. Lap press in RUN at `count`=8'h23, then 5 ticks → `display`=8'h23 while `count`=8'h28. A second lap press → `display`=8'h28.
6. Run and clr pressed in the same cycle while in PAUSE with hold set → one `clr` pulse, IDLE, `hold`=0, `running`=0. Asserting `sys_reset` mid-debounce → no event after release.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/lap controller between the 1 Hz ticker and the two-digit BCD chain.
// Raw buttons are synchronized, debounced and edge-detected before driving the control FSM.
module stopwatch_ctrl #(
    parameter int DEBOUNCE    = 120000,
    parameter bit STOP_AT_MAX = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_reset,
    input  logic       btn_run,
    input  logic       btn_clr,
    input  logic       btn_lap,
    input  logic       tick_in,
    input  logic [7:0] count,
    output logic       tick_out,
    output logic       clr,
    output logic       running,
    output logic       done,
    output logic [7:0] display
);
    localparam int            CW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int B_RUN = 0;
    localparam int B_CLR = 1;
    localparam int B_LAP = 2;

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_lap, btn_clr, btn_run};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          level_d_reg;
            logic          press_reg;
            logic [CW-1:0] cnt_reg;

            // The press pulse is registered off the delayed level so the FSM sees it one edge later.
            always_ff @(posedge sys_clk or posedge sys_reset) begin
                if (sys_reset) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    level_reg   <= 1'b0;
                    level_d_reg <= 1'b0;
                    press_reg   <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= btn_raw[gi];
                    sync2_reg   <= sync1_reg;
                    level_d_reg <= level_reg;
                    press_reg   <= level_reg & ~level_d_reg;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    logic       clr_ev;
    logic       run_ev;
    logic       lap_ev;
    logic       terminal;
    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       hold_reg;
    logic       hold_next;
    logic [7:0] lap_reg;
    logic [7:0] lap_next;
    logic       clr_reg;
    logic       running_reg;
    logic       done_reg;

    assign clr_ev   = press[B_CLR];
    assign run_ev   = press[B_RUN];
    assign lap_ev   = press[B_LAP];
    assign terminal = STOP_AT_MAX && tick_in && (count == 8'h99);

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        lap_next   = lap_reg;
        if (clr_ev) begin
            state_next = S_IDLE;
            hold_next  = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE:  if (run_ev) state_next = S_RUN;
                S_RUN: begin
                    if (terminal)    state_next = S_DONE;
                    else if (run_ev) state_next = S_PAUSE;
                end
                S_PAUSE: if (run_ev) state_next = S_RUN;
                default: state_next = state_reg;
            endcase
            // Lap only acts when it is the highest-priority event this cycle.
            if (lap_ev && !run_ev && (state_reg == S_RUN || state_reg == S_PAUSE)) begin
                hold_next = ~hold_reg;
                if (!hold_reg) lap_next = count;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_reg   <= S_IDLE;
            hold_reg    <= 1'b0;
            lap_reg     <= 8'h00;
            clr_reg     <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            lap_reg     <= lap_next;
            clr_reg     <= clr_ev;
            running_reg <= (state_next == S_RUN);
            done_reg    <= (state_next == S_DONE);
        end
    end

    assign tick_out = tick_in && (state_reg == S_RUN) && !clr_ev && !terminal;
    assign clr      = clr_reg;
    assign running  = running_reg;
    assign done     = done_reg;
    assign display  = hold_reg ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (wrap and stop-at-max) share button/tick stimulus,
// each with its own bench-driven digit chain, checked against a per-cycle behavioural model.
module tb_stopwatch_ctrl;
    localparam int DEB = 4;

    logic       sys_clk = 1'b0;
    logic       sys_reset;
    logic       btn_run, btn_clr, btn_lap, tick_in;
    logic [7:0] count_w, count_s;
    logic       tick_w, clr_w, running_w, done_w;
    logic       tick_s, clr_s, running_s, done_s;
    logic [7:0] disp_w, disp_s;

    always #5 sys_clk = ~sys_clk;

    stopwatch_ctrl #(.DEBOUNCE(DEB), .STOP_AT_MAX(1'b0)) dut_wrap (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .btn_run(btn_run), .btn_clr(btn_clr),
        .btn_lap(btn_lap), .tick_in(tick_in), .count(count_w), .tick_out(tick_w),
        .clr(clr_w), .running(running_w), .done(done_w), .display(disp_w)
    );

    stopwatch_ctrl #(.DEBOUNCE(DEB), .STOP_AT_MAX(1'b1)) dut_stop (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .btn_run(btn_run), .btn_clr(btn_clr),
        .btn_lap(btn_lap), .tick_in(tick_in), .count(count_s), .tick_out(tick_s),
        .clr(clr_s), .running(running_s), .done(done_s), .display(disp_s)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- behavioural reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;

    mode_t m_mode [2];
    bit    m_hold [2];
    int    m_lap  [2];
    int    m_n    [2];     // decimal value held by each digit chain
    int    m_pend [2];
    bit    m_clr  [2];
    bit    raw_hist [3][$]; // raw samples per button (0 run, 1 clr, 2 lap)
    bit    m_deb  [3];
    bit    pipe1  [3];
    bit    pipe2  [3];

    function automatic logic [7:0] to_bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    function automatic bit btn_level(input int b);
        if (b == 0) return btn_run;
        if (b == 1) return btn_clr;
        return btn_lap;
    endfunction

    function automatic logic exp_tick(input int i);
        bit stop_here;
        stop_here = (i == 1) && (m_n[i] == 99);
        return tick_in && (m_mode[i] == M_RUN) && !pipe2[1] && !stop_here;
    endfunction

    function automatic logic [7:0] exp_disp(input int i);
        return m_hold[i] ? to_bcd(m_lap[i]) : to_bcd(m_n[i]);
    endfunction

    task automatic drive_counts();
        count_w = to_bcd(m_n[0]);
        count_s = to_bcd(m_n[1]);
    endtask

    task automatic set_count(input int n);
        m_n[0] = n;
        m_n[1] = n;
        drive_counts();
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            raw_hist[b].delete();
            for (int k = 0; k < DEB + 2; k++) raw_hist[b].push_back(1'b0);
            m_deb[b] = 1'b0;
            pipe1[b] = 1'b0;
            pipe2[b] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE;
            m_hold[i] = 1'b0;
            m_lap[i]  = 0;
            m_clr[i]  = 1'b0;
            m_pend[i] = m_n[i];
        end
    endtask

    task automatic model_edge();
        bit ev_r, ev_c, ev_l, fwd, term, all_diff, rise;
        mode_t old;
        ev_r = pipe2[0];
        ev_c = pipe2[1];
        ev_l = pipe2[2];
        for (int i = 0; i < 2; i++) begin
            fwd  = exp_tick(i);
            term = (i == 1) && (m_mode[i] == M_RUN) && tick_in && (m_n[i] == 99);
            old  = m_mode[i];
            m_pend[i] = m_clr[i] ? 0 : (fwd ? (m_n[i] + 1) % 100 : m_n[i]);
            m_clr[i]  = ev_c;
            if (ev_c) begin
                m_mode[i] = M_IDLE;
                m_hold[i] = 1'b0;
            end else begin
                if (old == M_RUN && term)          m_mode[i] = M_DONE;
                else if (ev_r && old == M_IDLE)    m_mode[i] = M_RUN;
                else if (ev_r && old == M_RUN)     m_mode[i] = M_PAUSE;
                else if (ev_r && old == M_PAUSE)   m_mode[i] = M_RUN;
                if (ev_l && !ev_r && (old == M_RUN || old == M_PAUSE)) begin
                    if (!m_hold[i]) m_lap[i] = m_n[i];
                    m_hold[i] = !m_hold[i];
                end
            end
        end
        // A level is accepted once the last DEB synchronized samples all disagree with it.
        for (int b = 0; b < 3; b++) begin
            raw_hist[b].push_back(btn_level(b));
            void'(raw_hist[b].pop_front());
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++)
                if (raw_hist[b][k] == m_deb[b]) all_diff = 1'b0;
            rise = 1'b0;
            if (all_diff) begin
                m_deb[b] = !m_deb[b];
                rise     = m_deb[b];
            end
            pipe2[b] = pipe1[b];
            pipe1[b] = rise;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: inputs already driven after the previous negedge.
    task automatic run_cycle();
        #1;
        check_bit("w.tick_out", tick_w, exp_tick(0));
        check_bit("s.tick_out", tick_s, exp_tick(1));
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        m_n[0] = m_pend[0];
        m_n[1] = m_pend[1];
        drive_counts();
        #1;
        check_bit("w.running", running_w, m_mode[0] == M_RUN);
        check_bit("s.running", running_s, m_mode[1] == M_RUN);
        check_bit("w.done", done_w, m_mode[0] == M_DONE);
        check_bit("s.done", done_s, m_mode[1] == M_DONE);
        check_bit("w.clr", clr_w, m_clr[0]);
        check_bit("s.clr", clr_s, m_clr[1]);
        check_byte("w.display", disp_w, exp_disp(0));
        check_byte("s.display", disp_s, exp_disp(1));
    endtask

    task automatic do_reset(input int edges);
        tick_in   = 1'b1;
        sys_reset = 1'b1;
        model_reset();
        #1;
        check_bit("rst.w.running", running_w, 1'b0);
        check_bit("rst.s.running", running_s, 1'b0);
        check_bit("rst.w.done", done_w, 1'b0);
        check_bit("rst.w.clr", clr_w, 1'b0);
        check_bit("rst.w.tick_out", tick_w, 1'b0);
        check_bit("rst.s.tick_out", tick_s, 1'b0);
        check_byte("rst.w.display", disp_w, to_bcd(m_n[0]));
        check_byte("rst.s.display", disp_s, to_bcd(m_n[1]));
        repeat (edges) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_reset = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       b_run, b_clr, b_lap, b_tick;
        int         cycles;
        int         preload;
        logic       run_w, done_w, run_s, done_s;
        logic [7:0] disp_w, disp_s;
        int         nclr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic c, input logic l, input logic t,
                                input int cyc, input int pre,
                                input logic rw, input logic dw, input logic rs, input logic ds,
                                input logic [7:0] pw, input logic [7:0] ps, input int nclr);
        vec_t v;
        v.b_run = r;  v.b_clr = c;  v.b_lap = l;  v.b_tick = t;
        v.cycles = cyc;  v.preload = pre;
        v.run_w = rw;  v.done_w = dw;  v.run_s = rs;  v.done_s = ds;
        v.disp_w = pw;  v.disp_s = ps;  v.nclr = nclr;
        return v;
    endfunction

    initial begin
        int  clr_cnt_w, clr_cnt_s, first_edge;
        bit  lvl[3];
        int  dur[3];

        //               run clr lap tick cyc pre   rw dw rs ds  disp_w disp_s clrs
        tbl.push_back(mk(0, 0, 0, 0,  2, -1,  0, 0, 0, 0, 8'h00, 8'h00, 0)); // after reset
        tbl.push_back(mk(1, 0, 0, 0,  3, -1,  0, 0, 0, 0, 8'h00, 8'h00, 0)); // 3-cycle glitch
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  0, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, 0, 0, 10, -1,  1, 0, 1, 0, 8'h00, 8'h00, 0)); // run
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  1, 0, 1, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 1,  2, -1,  1, 0, 1, 0, 8'h02, 8'h02, 0)); // 00->02
        tbl.push_back(mk(1, 0, 0, 0, 10, -1,  0, 0, 0, 0, 8'h02, 8'h02, 0)); // pause
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  0, 0, 0, 0, 8'h02, 8'h02, 0));
        tbl.push_back(mk(0, 0, 0, 1,  3, -1,  0, 0, 0, 0, 8'h02, 8'h02, 0)); // ticks blocked
        tbl.push_back(mk(1, 0, 0, 0, 10, 99,  1, 0, 1, 0, 8'h99, 8'h99, 0)); // resume at 99
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  1, 0, 1, 0, 8'h99, 8'h99, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, -1,  1, 0, 0, 1, 8'h00, 8'h99, 0)); // wrap vs stop
        tbl.push_back(mk(1, 0, 0, 0, 10, -1,  0, 0, 0, 1, 8'h00, 8'h99, 0)); // run ignored in DONE
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  0, 0, 0, 1, 8'h00, 8'h99, 0));
        tbl.push_back(mk(0, 1, 0, 0, 10, -1,  0, 0, 0, 0, 8'h00, 8'h00, 1)); // clear
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  0, 0, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 0, 0, 0, 10, -1,  1, 0, 1, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  1, 0, 1, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 0, 1, 0, 10, 23,  1, 0, 1, 0, 8'h23, 8'h23, 0)); // lap at 23
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  1, 0, 1, 0, 8'h23, 8'h23, 0));
        tbl.push_back(mk(0, 0, 0, 1,  5, -1,  1, 0, 1, 0, 8'h23, 8'h23, 0)); // counts to 28
        tbl.push_back(mk(0, 0, 1, 0, 10, -1,  1, 0, 1, 0, 8'h28, 8'h28, 0)); // unhold
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  1, 0, 1, 0, 8'h28, 8'h28, 0));
        tbl.push_back(mk(0, 0, 1, 0, 10, -1,  1, 0, 1, 0, 8'h28, 8'h28, 0)); // hold again
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  1, 0, 1, 0, 8'h28, 8'h28, 0));
        tbl.push_back(mk(1, 0, 0, 0, 10, -1,  0, 0, 0, 0, 8'h28, 8'h28, 0)); // pause, held
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  0, 0, 0, 0, 8'h28, 8'h28, 0));
        tbl.push_back(mk(1, 1, 0, 0, 10, -1,  0, 0, 0, 0, 8'h00, 8'h00, 1)); // run+clr together
        tbl.push_back(mk(0, 0, 0, 0,  8, -1,  0, 0, 0, 0, 8'h00, 8'h00, 0));

        btn_run = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0; tick_in = 1'b0;
        m_n[0] = 0; m_n[1] = 0;
        drive_counts();
        do_reset(2);
        tick_in = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            btn_run = tbl[r].b_run;
            btn_clr = tbl[r].b_clr;
            btn_lap = tbl[r].b_lap;
            tick_in = tbl[r].b_tick;
            if (tbl[r].preload >= 0) set_count(tbl[r].preload);
            clr_cnt_w = 0;
            clr_cnt_s = 0;
            for (int c = 0; c < tbl[r].cycles; c++) begin
                run_cycle();
                if (clr_w) clr_cnt_w++;
                if (clr_s) clr_cnt_s++;
            end
            check_bit($sformatf("row%0d.running_w", r), running_w, tbl[r].run_w);
            check_bit($sformatf("row%0d.done_w", r), done_w, tbl[r].done_w);
            check_bit($sformatf("row%0d.running_s", r), running_s, tbl[r].run_s);
            check_bit($sformatf("row%0d.done_s", r), done_s, tbl[r].done_s);
            check_byte($sformatf("row%0d.display_w", r), disp_w, tbl[r].disp_w);
            check_byte($sformatf("row%0d.display_s", r), disp_s, tbl[r].disp_s);
            check_byte($sformatf("row%0d.clr_pulses_w", r), 8'(clr_cnt_w), 8'(tbl[r].nclr));
            check_byte($sformatf("row%0d.clr_pulses_s", r), 8'(clr_cnt_s), 8'(tbl[r].nclr));
        end
        btn_run = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0; tick_in = 1'b0;

        // Press latency: first sampled-high edge is edge 0, running must rise on edge DEB+3.
        first_edge = -1;
        btn_run = 1'b1;
        for (int k = 0; k < 10; k++) begin
            run_cycle();
            if (running_w && first_edge < 0) first_edge = k;
        end
        check_byte("latency.run_press", 8'(first_edge), 8'(DEB + 3));
        btn_run = 1'b0;
        repeat (8) run_cycle();

        // Reset while a second run press is still being debounced.
        btn_run = 1'b1;
        repeat (3) run_cycle();
        do_reset(2);
        btn_run = 1'b0;
        tick_in = 1'b0;
        clr_cnt_w = 0;
        for (int k = 0; k < 12; k++) begin
            run_cycle();
            if (running_w || clr_w) clr_cnt_w++;
        end
        check_byte("reset_mid_debounce.activity", 8'(clr_cnt_w), 8'd0);
        check_bit("reset_mid_debounce.running", running_w, 1'b0);

        // Randomized phase against the model.
        for (int b = 0; b < 3; b++) begin
            lvl[b] = 1'b0;
            dur[b] = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (dur[b] == 0) begin
                    lvl[b] = ($urandom_range(0, 99) < ((b == 1) ? 15 : 40));
                    dur[b] = $urandom_range(1, 14);
                end
                dur[b]--;
            end
            btn_run = lvl[0];
            btn_clr = lvl[1];
            btn_lap = lvl[2];
            tick_in = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 2))
                    0:       set_count(99);
                    1:       set_count(98);
                    default: set_count(int'($urandom_range(0, 99)));
                endcase
            end
            if ($urandom_range(0, 799) == 0) do_reset(int'($urandom_range(1, 3)));
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
